// File: rtl/graycode_updown_counter_pkg.sv
// Shared Gray-code helpers and width defaults for the up/down Gray counter.
// The functions work on zero-extended values, so any width up to GRAY_MAX_W is handled.
package gray_pkg;

  localparam int GRAY_W     = 4;
  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB; zero upper bits leave narrower codes intact.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/graycode_updown_counter_if.sv
// Direction control and Gray-code count output of the counter, grouped as one bundle.
interface graycode_updown_counter_if
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
);
  logic             dir;
  logic [WIDTH-1:0] gray;

  modport master (output dir, input  gray);
  modport slave  (input  dir, output gray);
endinterface

// File: rtl/graycode_updown_counter_next_calc.sv
// Combinational step of the counter: next binary value and its Gray encoding.
module gray_next_calc
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic [WIDTH-1:0] bin,
  input  logic             dir,
  output logic [WIDTH-1:0] bin_next,
  output logic [WIDTH-1:0] gray_next
);

  // Natural modulo-2^WIDTH wrap from the fixed-width add/subtract.
  assign bin_next  = dir ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
  assign gray_next = WIDTH'(bin2gray(GRAY_MAX_W'(bin_next)));

endmodule

// File: rtl/graycode_updown_counter.sv
// Up/down counter whose visible output is a registered Gray code, stepping every cycle.
module graycode_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W
) (
  input  logic                            clk,
  input  logic                            rst,
  graycode_updown_counter_if.slave        bus
);

  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] gray_reg;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;

  gray_next_calc #(
    .WIDTH (WIDTH)
  ) u_next (
    .bin       (bin_reg),
    .dir       (bus.dir),
    .bin_next  (bin_next),
    .gray_next (gray_next)
  );

  // Gray output comes straight from its own flop so it never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_reg  <= '0;
      gray_reg <= '0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
    end
  end

  assign bus.gray = gray_reg;

endmodule

// File: tb/tb_graycode_updown_counter.sv
// Scoreboard bench for the Gray up/down counter: expected codes are queued at drive time.
module tb_graycode_updown_counter;
  import gray_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  graycode_updown_counter_if #(.WIDTH(W)) bus ();

  graycode_updown_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] model_bin  = '0;
  logic [W-1:0] prev_gray  = '0;
  logic         have_prev  = 1'b0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One transaction: drive, predict, clock, then compare away from the edge.
  task automatic step(input logic r, input logic d, input string tag);
    logic [W-1:0] exp_gray;
    logic [W-1:0] got;
    @(negedge clk);
    rst     = r;
    bus.dir = d;
    if (r) model_bin = '0;
    else if (d) model_bin = model_bin + 1'b1;
    else model_bin = model_bin - 1'b1;
    exp_gray = model_bin ^ {1'b0, model_bin[W-1:1]};
    exp_q.push_back(exp_gray);
    @(posedge clk);
    #1;
    got = bus.gray;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
    end else begin
      exp_gray = exp_q.pop_front();
      check({tag, "_gray"}, int'(got), int'(exp_gray));
      check({tag, "_bin"}, int'(W'(gray2bin(GRAY_MAX_W'(got)))), int'(model_bin));
      if (!r && have_prev)
        check({tag, "_hamming"}, $countones(got ^ prev_gray), 1);
    end
    $display("step %-8s rst=%0b dir=%0b gray=%b exp=%b", tag, r, d, got, exp_gray);
    prev_gray = got;
    have_prev = 1'b1;
  endtask

  initial begin
    bus.dir = 1'b1;

    step(1'b1, 1'b1, "reset");
    check("reset_const", int'(bus.gray), 0);

    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, "up12");
    check("up12_end", int'(bus.gray), 'b1010);

    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, "down12");
    check("down12_end", int'(bus.gray), 0);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, "wrapup");
      if (i == 14) check("wrapup_max", int'(bus.gray), 'b1000);
    end
    check("wrapup_end", int'(bus.gray), 0);

    step(1'b0, 1'b0, "wrapdn");
    check("wrapdn_end", int'(bus.gray), 'b1000);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "pre_rst");
    step(1'b1, 1'b1, "mid_rst");
    check("mid_rst_const", int'(bus.gray), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "up8");
    check("up8_end", int'(bus.gray), 'b1100);

    step(1'b1, 1'b0, "rst_dn");
    for (int i = 0; i < 10; i++) begin
      step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, "toggle");
      check("toggle_val", int'(bus.gray), (i % 2 == 0) ? 1 : 0);
    end

    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), "random");

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
